// File: rtl/dual_issue_sched_if.sv
// Fetch/issue bundle between the fetch stage, the instruction queue and
// the pair decoder. The slave modport is the scheduler's view.
interface dual_issue_sched_if #(
  parameter int data_width_p = 32,
  parameter int ctr_width_p  = 16
);
  logic                    fetch_v_i;
  logic [data_width_p-1:0] fetch_instr_i;
  logic                    fetch_ready_o;
  logic [data_width_p-1:0] instr0_o;
  logic [data_width_p-1:0] instr1_o;
  logic                    instr1_v_o;
  logic                    dual_issue_i;
  logic                    stall_i;
  logic                    flush_i;
  logic                    issue_v_o;
  logic                    issue_two_o;
  logic [ctr_width_p-1:0]  dual_count_o;

  modport slave (
    input  fetch_v_i, fetch_instr_i, dual_issue_i, stall_i, flush_i,
    output fetch_ready_o, instr0_o, instr1_o, instr1_v_o,
           issue_v_o, issue_two_o, dual_count_o
  );

  modport master (
    output fetch_v_i, fetch_instr_i, dual_issue_i, stall_i, flush_i,
    input  fetch_ready_o, instr0_o, instr1_o, instr1_v_o,
           issue_v_o, issue_two_o, dual_count_o
  );
endinterface

// File: rtl/dual_issue_sched.sv
// Dual-issue instruction queue: circular FIFO presenting its two oldest
// entries to the pair decoder and retiring one or two per issue.
module dual_issue_sched #(
  parameter int els_p        = 4,
  parameter int data_width_p = 32,
  parameter int ctr_width_p  = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  dual_issue_sched_if.slave bus
);
  localparam int aw_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cw_lp = $clog2(els_p + 1);
  localparam logic [cw_lp-1:0] full_lp = cw_lp'(els_p);

  logic [data_width_p-1:0] mem_q [els_p];
  logic [aw_lp-1:0]        rptr_q, rptr_d, wptr_q, wptr_d, rptr_p1;
  logic [cw_lp-1:0]        count_q, count_d;
  logic [ctr_width_p-1:0]  dual_cnt_q, dual_cnt_d;
  logic                    fetch_ready, enq, instr1_v, issue_v, issue_two;
  logic [1:0]              deq;

  // Pointers wrap for free because els_p is a power of two.
  assign rptr_p1     = rptr_q + aw_lp'(1);
  assign fetch_ready = (count_q < full_lp);
  assign enq         = bus.fetch_v_i & fetch_ready & ~bus.flush_i;
  assign instr1_v    = (count_q >= cw_lp'(2));
  assign issue_v     = (count_q != '0) & ~bus.stall_i & ~bus.flush_i;
  assign issue_two   = issue_v & instr1_v & bus.dual_issue_i;

  assign bus.fetch_ready_o = fetch_ready;
  assign bus.instr0_o      = mem_q[rptr_q];
  assign bus.instr1_o      = mem_q[rptr_p1];
  assign bus.instr1_v_o    = instr1_v;
  assign bus.issue_v_o     = issue_v;
  assign bus.issue_two_o   = issue_two;
  assign bus.dual_count_o  = dual_cnt_q;

  // Next-state for pointers, occupancy and the dual-issue statistic.
  always_comb begin
    deq        = 2'd0;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    dual_cnt_d = dual_cnt_q;
    if (issue_two)    deq = 2'd2;
    else if (issue_v) deq = 2'd1;
    if (bus.flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      rptr_d  = rptr_q + aw_lp'(deq);
      if (enq) wptr_d = wptr_q + aw_lp'(1);
      count_d = count_q + cw_lp'(enq) - cw_lp'(deq);
    end
    // Statistic survives flush and saturates at all-ones.
    if (issue_two && (dual_cnt_q != '1)) dual_cnt_d = dual_cnt_q + ctr_width_p'(1);
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      dual_cnt_q <= '0;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      dual_cnt_q <= dual_cnt_d;
    end
  end

  // Queue storage; contents only matter while qualified by count.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= bus.fetch_instr_i;
  end
endmodule

// File: tb/tb_dual_issue_sched.sv
module tb_dual_issue_sched;
  localparam int ELS = 4;
  localparam int DW  = 32;
  localparam int CW  = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: an ordered list of queued instructions plus a counter.
  logic [DW-1:0] mq[$];
  int            m_dual;

  dual_issue_sched_if #(.data_width_p(DW), .ctr_width_p(CW)) bus ();

  dual_issue_sched #(.els_p(ELS), .data_width_p(DW), .ctr_width_p(CW)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare against the model, then advance the model.
  task automatic step(input logic fv, input logic [DW-1:0] ins,
                      input logic di, input logic st, input logic fl);
    bit exp_v, exp_two, exp_enq;
    int sz;
    @(negedge clk);
    bus.fetch_v_i     = fv;
    bus.fetch_instr_i = ins;
    bus.dual_issue_i  = di;
    bus.stall_i       = st;
    bus.flush_i       = fl;
    #1;
    sz      = mq.size();
    exp_v   = (sz >= 1) && !st && !fl;
    exp_two = exp_v && (sz >= 2) && di;
    exp_enq = fv && (sz < ELS) && !fl;
    check("fetch_ready", bus.fetch_ready_o, sz < ELS);
    check("instr1_v", bus.instr1_v_o, sz >= 2);
    check("issue_v", bus.issue_v_o, exp_v);
    check("issue_two", bus.issue_two_o, exp_two);
    check("dual_count", bus.dual_count_o, m_dual);
    if (sz >= 1) check("instr0", bus.instr0_o, mq[0]);
    if (sz >= 2) check("instr1", bus.instr1_o, mq[1]);
    if (fl) begin
      mq.delete();
    end else begin
      if (exp_two) begin
        void'(mq.pop_front());
        void'(mq.pop_front());
        if (m_dual < (1 << CW) - 1) m_dual++;
      end else if (exp_v) begin
        void'(mq.pop_front());
      end
      if (exp_enq) mq.push_back(ins);
    end
  endtask

  // Assert reset mid-cycle and confirm the cleared outputs before any clock edge.
  task automatic do_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_ready", bus.fetch_ready_o, 1'b1);
    check("rst_issue_v", bus.issue_v_o, 1'b0);
    check("rst_issue_two", bus.issue_two_o, 1'b0);
    check("rst_instr1_v", bus.instr1_v_o, 1'b0);
    check("rst_dual_count", bus.dual_count_o, 0);
    mq.delete();
    m_dual = 0;
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    reset_n           = 1'b0;
    bus.fetch_v_i     = 1'b0;
    bus.fetch_instr_i = '0;
    bus.dual_issue_i  = 1'b0;
    bus.stall_i       = 1'b0;
    bus.flush_i       = 1'b0;
    m_dual            = 0;
    do_reset();

    // Fill under stall: fifth offer held off by fetch_ready.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(32'hA0 + i), 1'b0, 1'b1, 1'b0);
    check("fill_full_ready", bus.fetch_ready_o, 1'b0);
    step(1'b0, '0, 1'b0, 0, 0);

    // Pair issue.
    do_reset();
    step(1'b1, 32'h10, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h20, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("pair_dual_count", bus.dual_count_o, 1);

    // Singleton with dual verdict asserted.
    do_reset();
    step(1'b1, 32'h10, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Wrap: move rptr to 3 with a fresh entry at 0, then dual-issue the straddling pair.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, DW'(32'hB0 + i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB4, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("wrap_pair_instr0", bus.instr0_o, 32'hB3);
    step(1'b1, 32'hB5, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'hB6, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush collides with fetch and a dual-issuable pair.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, DW'(32'hC0 + i), 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'hCC, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("flush_empty_instr1_v", bus.instr1_v_o, 1'b0);

    // Saturation of the two-bit statistic, then asynchronous clear.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'(32'hD0 + 2 * i), 1'b0, 1'b1, 1'b0);
      step(1'b1, DW'(32'hD1 + 2 * i), 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("sat_dual_count", bus.dual_count_o, 3);
    do_reset();

    // Randomized traffic with occasional flush and mid-run reset.
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
           $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
